// File: rtl/ex_mem_stage.sv
// EX/MEM stage: picks the ALU result, registers it with MEM/WB control through a 2-entry skid buffer.
// Optional overflow trap enabled by defining EX_OVF_TRAP_EN.
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_sel,
    input  logic              alu_sub,
    input  logic [DATA_W-1:0] alu_sum,
    input  logic [DATA_W-1:0] alu_and,
    input  logic [DATA_W-1:0] alu_or,
    input  logic              alu_slt,
    input  logic              op_a31,
    input  logic              op_b31,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_reg_write,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic [DATA_W-1:0] out_store_data,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_ovf,
    output logic              fwd_we,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [DATA_W-1:0] fwd_data
);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic [DATA_W-1:0] store_data;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              ovf;
    } entry_t;

    entry_t            in_e, main_q, skid_q;
    logic              main_v, skid_v;
    logic [DATA_W-1:0] result;
    logic              ovf_raw;
    logic              accept, drain;

    always_comb begin
        result = '0;
        unique case (alu_sel)
            2'b00: result = alu_and;
            2'b01: result = alu_or;
            2'b10: result = alu_sum;
            2'b11: result = {{(DATA_W-1){1'b0}}, alu_slt};
        endcase
    end

    // Signed overflow: operands (after subtract inversion) agree in sign, sum disagrees.
    assign ovf_raw = (alu_sel == 2'b10) && (op_a31 == (op_b31 ^ alu_sub))
                     && (alu_sum[DATA_W-1] != op_a31);

    always_comb begin
        in_e            = '0;
        in_e.result     = result;
        in_e.zero       = (result == '0);
        in_e.store_data = in_store_data;
        in_e.rd         = in_rd;
        in_e.mem_read   = in_mem_read;
        in_e.mem_write  = in_mem_write;
`ifdef EX_OVF_TRAP_EN
        in_e.ovf        = ovf_raw;
        in_e.reg_write  = in_reg_write & ~ovf_raw;
`else
        in_e.ovf        = 1'b0;
        in_e.reg_write  = in_reg_write;
`endif
    end

`ifndef EX_OVF_TRAP_EN
    logic ovf_unused;
    assign ovf_unused = ovf_raw;
`endif

    // in_ready comes only from skid_v, so out_ready never reaches it combinationally.
    assign in_ready = ~skid_v;
    assign accept   = in_valid & in_ready;
    assign drain    = main_v & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (drain) begin
            if (skid_v) begin
                main_q <= skid_q;
                skid_v <= 1'b0;
            end else if (accept) begin
                main_q <= in_e;
            end else begin
                main_v <= 1'b0;
            end
        end else if (!main_v) begin
            if (accept) begin
                main_q <= in_e;
                main_v <= 1'b1;
            end
        end else if (accept) begin
            skid_q <= in_e;
            skid_v <= 1'b1;
        end
    end

    assign out_valid      = main_v;
    assign out_result     = main_q.result;
    assign out_zero       = main_q.zero;
    assign out_store_data = main_q.store_data;
    assign out_rd         = main_q.rd;
    assign out_reg_write  = main_q.reg_write;
    assign out_mem_read   = main_q.mem_read;
    assign out_mem_write  = main_q.mem_write;
    assign out_ovf        = main_q.ovf;

    assign fwd_we   = main_v & main_q.reg_write & (main_q.rd != '0);
    assign fwd_rd   = main_q.rd;
    assign fwd_data = main_q.result;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: result select, skid handshake, flush, reset, forwarding.
module tb_ex_mem_stage;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready;
    logic [1:0]  alu_sel;
    logic        alu_sub, alu_slt, op_a31, op_b31;
    logic [31:0] alu_sum, alu_and, alu_or, in_store_data;
    logic [4:0]  in_rd;
    logic        in_reg_write, in_mem_read, in_mem_write;
    logic        out_valid, out_ready, out_zero;
    logic [31:0] out_result, out_store_data, fwd_data;
    logic [4:0]  out_rd, fwd_rd;
    logic        out_reg_write, out_mem_read, out_mem_write, out_ovf, fwd_we;

    int passed = 0;
    int total  = 0;

    ex_mem_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alu_sel(alu_sel), .alu_sub(alu_sub), .alu_sum(alu_sum), .alu_and(alu_and),
        .alu_or(alu_or), .alu_slt(alu_slt), .op_a31(op_a31), .op_b31(op_b31),
        .in_store_data(in_store_data), .in_rd(in_rd), .in_reg_write(in_reg_write),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_store_data(out_store_data), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_ovf(out_ovf),
        .fwd_we(fwd_we), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [1:0] sel, input logic [31:0] d,
                       input logic [4:0] rd);
        in_valid      = v;
        alu_sel       = sel;
        alu_sum       = d;
        alu_and       = d;
        alu_or        = d;
        alu_slt       = 1'b0;
        alu_sub       = 1'b0;
        op_a31        = 1'b0;
        op_b31        = 1'b0;
        in_store_data = ~d;
        in_rd         = rd;
        in_reg_write  = 1'b1;
        in_mem_read   = 1'b1;
        in_mem_write  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        drv(1'b0, 2'b00, 32'h0, 5'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
        total++; if (out_result !== 32'h0) $display("FAIL reset_result got %h want 0", out_result); else passed++;
        total++; if ({out_zero, out_rd, out_reg_write, out_mem_read, out_mem_write, out_ovf, fwd_we} !== 11'h0)
            $display("FAIL reset_ctrl got %b want 0", {out_zero, out_rd, out_reg_write, out_mem_read, out_mem_write, out_ovf, fwd_we});
        else passed++;
    endtask

    task automatic test_add_ovf();
        logic exp_ovf, exp_rw;
`ifdef EX_OVF_TRAP_EN
        exp_ovf = 1'b1; exp_rw = 1'b0;
`else
        exp_ovf = 1'b0; exp_rw = 1'b1;
`endif
        out_ready = 1'b1;
        drv(1'b1, 2'b10, 32'h8000_0000, 5'd4);
        step();
        drv(1'b0, 2'b00, 32'h0, 5'd0);
        total++; if (out_valid !== 1'b1) $display("FAIL add_valid got %b want 1", out_valid); else passed++;
        total++; if (out_result !== 32'h8000_0000) $display("FAIL add_result got %h want 80000000", out_result); else passed++;
        total++; if (out_zero !== 1'b0) $display("FAIL add_zero got %b want 0", out_zero); else passed++;
        total++; if (out_ovf !== exp_ovf) $display("FAIL add_ovf got %b want %b", out_ovf, exp_ovf); else passed++;
        total++; if (out_reg_write !== exp_rw) $display("FAIL add_reg_write got %b want %b", out_reg_write, exp_rw); else passed++;
        total++; if (fwd_we !== exp_rw) $display("FAIL add_fwd_we got %b want %b", fwd_we, exp_rw); else passed++;
        // Non-overflowing subtract: 1 - 1 -> sum 0, zero flag set, no trap.
        drv(1'b1, 2'b10, 32'h0, 5'd4);
        alu_sub = 1'b1; op_b31 = 1'b0;
        step();
        drv(1'b0, 2'b00, 32'h0, 5'd0);
        total++; if ({out_zero, out_ovf, out_reg_write} !== 3'b101)
            $display("FAIL sub_flags got %b want 101", {out_zero, out_ovf, out_reg_write}); else passed++;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL add_drained got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_slt_or();
        out_ready = 1'b1;
        drv(1'b1, 2'b11, 32'hFFFF_FFFF, 5'd1);
        alu_slt = 1'b1;
        step();
        total++; if (out_result !== 32'h1) $display("FAIL slt_result got %h want 1", out_result); else passed++;
        total++; if (out_zero !== 1'b0) $display("FAIL slt_zero got %b want 0", out_zero); else passed++;
        drv(1'b1, 2'b01, 32'h5, 5'd2);
        alu_or = 32'h0;
        step();
        total++; if (out_result !== 32'h0) $display("FAIL or_result got %h want 0", out_result); else passed++;
        total++; if (out_zero !== 1'b1) $display("FAIL or_zero got %b want 1", out_zero); else passed++;
        drv(1'b1, 2'b00, 32'h0, 5'd3);
        alu_and = 32'h0000_00F0; alu_or = 32'h0; alu_sum = 32'h0;
        step();
        drv(1'b0, 2'b00, 32'h0, 5'd0);
        total++; if (out_result !== 32'h0000_00F0) $display("FAIL and_result got %h want f0", out_result); else passed++;
        step();
    endtask

    task automatic test_skid();
        logic [4:0] seen [$];
        int         when [$];
        out_ready = 1'b0;
        drv(1'b1, 2'b00, 32'h11, 5'd1);
        step();
        total++; if (in_ready !== 1'b1) $display("FAIL skid_ready1 got %b want 1", in_ready); else passed++;
        drv(1'b1, 2'b00, 32'h22, 5'd2);
        step();
        total++; if (in_ready !== 1'b0) $display("FAIL skid_ready2 got %b want 0", in_ready); else passed++;
        drv(1'b1, 2'b00, 32'h33, 5'd3);
        step();
        total++; if (out_rd !== 5'd1 || out_result !== 32'h11)
            $display("FAIL skid_hold got rd=%0d res=%h want rd=1 res=11", out_rd, out_result); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL skid_stall_ready got %b want 0", in_ready); else passed++;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            logic acc;
            if (out_valid) begin seen.push_back(out_rd); when.push_back(c); end
            acc = in_valid & in_ready;
            step();
            if (acc) in_valid = 1'b0;
        end
        total++; if (seen.size() != 3) $display("FAIL skid_count got %0d want 3", seen.size()); else passed++;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (k >= seen.size()) $display("FAIL skid_order[%0d] got none want %0d", k, k + 1);
            else if (seen[k] !== 5'(k + 1)) $display("FAIL skid_order[%0d] got %0d want %0d", k, seen[k], k + 1);
            else passed++;
        end
        total++; if (when.size() != 3 || when[2] - when[0] != 2)
            $display("FAIL skid_gap got %0d entries span %0d want 3 span 2", when.size(), when.size() == 3 ? when[2] - when[0] : -1);
        else passed++;
    endtask

    task automatic test_flush();
        // Both entries full, flush with pending input.
        out_ready = 1'b0;
        drv(1'b1, 2'b00, 32'h77, 5'd7); step();
        drv(1'b1, 2'b00, 32'h88, 5'd8); step();
        drv(1'b1, 2'b00, 32'h99, 5'd9);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drv(1'b0, 2'b00, 32'h0, 5'd0);
        total++; if (out_valid !== 1'b0) $display("FAIL flush_full_valid got %b want 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL flush_full_ready got %b want 1", in_ready); else passed++;
        // Main only full: input is accepted during flush but must be discarded.
        drv(1'b1, 2'b00, 32'hAA, 5'd10); step();
        drv(1'b1, 2'b00, 32'hBB, 5'd11);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drv(1'b0, 2'b00, 32'h0, 5'd0);
        out_ready = 1'b1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL flush_accept got valid=%b ready=%b want 0 1", out_valid, in_ready); else passed++;
        begin
            int leaked = 0;
            for (int c = 0; c < 4; c++) begin
                if (out_valid) leaked++;
                step();
            end
            total++; if (leaked != 0) $display("FAIL flush_leak got %0d want 0", leaked); else passed++;
        end
    endtask

    task automatic test_stream(input logic [4:0] rd);
        int bad = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drv(1'b1, 2'b10, 32'h100 + 32'(i), rd);
            step();
            if (out_valid !== 1'b1 || out_result !== 32'h100 + 32'(i) || out_rd !== rd
                || fwd_we !== (rd != 5'd0) || fwd_rd !== rd || fwd_data !== 32'h100 + 32'(i)
                || out_store_data !== ~(32'h100 + 32'(i)) || out_mem_read !== 1'b1 || out_mem_write !== 1'b0) begin
                bad++;
                $display("FAIL stream_rd%0d[%0d] got v=%b res=%h rd=%0d we=%b want v=1 res=%h rd=%0d we=%b",
                         rd, i, out_valid, out_result, out_rd, fwd_we, 32'h100 + 32'(i), rd, rd != 5'd0);
            end
        end
        total++; if (bad == 0) passed++;
        drv(1'b0, 2'b00, 32'h0, 5'd0);
        step();
        total++; if (out_valid !== 1'b0 || fwd_we !== 1'b0)
            $display("FAIL stream_end got v=%b we=%b want 0 0", out_valid, fwd_we); else passed++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drv(1'b1, 2'b00, 32'hC0DE, 5'd12); step();
        drv(1'b1, 2'b00, 32'hBEEF, 5'd13); step();
        drv(1'b0, 2'b00, 32'h0, 5'd0);
        total++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL rstmid_pre got v=%b r=%b want 1 0", out_valid, in_ready); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'h0)
            $display("FAIL rstmid got v=%b r=%b res=%h want 0 1 0", out_valid, in_ready, out_result); else passed++;
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL rstmid_lost got %b want 0", out_valid); else passed++;
    endtask

    initial begin
        test_reset();
        test_add_ovf();
        test_slt_or();
        test_skid();
        test_flush();
        test_stream(5'd5);
        test_stream(5'd0);
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule
